regfile_param: RTL and testbench
================================

# regfile_param

Parametrised register bank for the NRISC datapath, successor to the fixed 8×8 bank. It generalises data width and register count and provides two registered read ports with one-cycle latency, one write port, and same-cycle write-to-read bypass. It also adds a per-register busy scoreboard so the control unit can stall reads of registers with an outstanding write. It sits between the decode stage (read addresses, reservations) and the writeback stage (write port).

## Interface
- `DATA_W`, default 8: register width in bits.
- `ADDR_W`, default 3: address width. Depth is 2^ADDR_W registers.
- `ZERO_REG`, default 0: when 1, register 0 always reads 0, ignores writes and is never busy.
- `BYPASS`, default 1: when 1, a same-cycle write is forwarded to a read of the same address.

Ports:
- `clk` input 1: single clock. All state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `rd_en` input 1: read request for both read ports this cycle.
- `rd_addr1` input ADDR_W: read port 1 address.
- `rd_addr2` input ADDR_W: read port 2 address.
- `rd_data1` output DATA_W: registered read data, port 1.
- `rd_data2` output DATA_W: registered read data, port 2.
- `rd_valid` output 1: pulses one cycle after an accepted (non-stalled) read.
- `wr_en` input 1: write enable.
- `wr_addr` input ADDR_W: write address.
- `wr_data` input DATA_W: write data.
- `rsv_en` input 1: reserve a destination register, which sets its busy bit.
- `rsv_addr` input ADDR_W: register to reserve.
- `stall` output 1: combinational. A read this cycle is refused because a source register is busy.

## Operation
- Storage: 2^ADDR_W × DATA_W registers plus a busy bit per register.
- Reset (async assert) clears:
  - all registers to 0
  - all busy bits to 0
  - `rd_data1`, `rd_data2` and `rd_valid` to 0
- Write: on a rising edge with `wr_en`=1, `reg[wr_addr]` is updated to `wr_data` and `busy[wr_addr]` is cleared.
  - With `ZERO_REG`=1 and `wr_addr`=0, the write is ignored.
- Reserve: on a rising edge with `rsv_en`=1, `busy[rsv_addr]` is set.
  - With `ZERO_REG`=1 and `rsv_addr`=0, the reserve is ignored.
- Same address written and reserved in the same cycle: reserve wins, so busy ends at 1 and data is still written.
- Source-busy term per port *n*: `busy[rd_addrn]`=1, unless `BYPASS`=1 and `wr_en`=1 and `wr_addr`=`rd_addrn`. In that case the term is 0, because the write resolves the dependency.
- Stall: `stall` = `rd_en` AND (source-busy term of port 1 OR source-busy term of port 2).
  - A read is accepted when `rd_en`=1 and `stall`=0.
- Accepted read, for each port: `rd_datan` ← source value, and `rd_valid` ← 1.
  - The source value is `wr_data` if `BYPASS`=1, `wr_en`=1, `wr_addr`=`rd_addrn` and the address is not the zero register.
  - Otherwise the source value is `reg[rd_addrn]` before the edge.
  - With `BYPASS`=0, the old value is returned.
- Zero register: with `ZERO_REG`=1, address 0 reads as 0 in every path, including bypass.
- Not accepted (`rd_en`=0 or stall): `rd_datan` hold their previous values and `rd_valid` ← 0.
- Both ports may use the same address. Each independently returns the same value.

## Timing
- Read latency: 1 cycle. Address sampled at edge N, data and `rd_valid` visible after edge N.
- Write latency: 1 cycle. Data written at edge N is readable by a read sampled at edge N+1. With `BYPASS`=1 it is also readable at edge N.
- `stall` is purely combinational from `rd_en`, `rd_addr*`, `wr_en`, `wr_addr` and the busy bits. There is no path from `rsv_*` to `stall` in the same cycle.
- Reset mid-operation: outputs go to 0 immediately. In-flight reads and reserves are lost. The first edge after deassertion behaves normally.
- `wr_en` with `rsv_en` on different addresses: both take effect on the same edge.

## Test plan
- Reset then read: assert `rst`, release, read r3 and r5 → `rd_data1`=`rd_data2`=0, `rd_valid`=1 one cycle later.
- Write then read: write 8'hA5 to r2 at edge N, read r2/r2 at edge N+1 → both ports 8'hA5.
- Bypass: in the same cycle write 8'h3C to r4 and read r4/r1 with r1=8'h11 → 8'h3C / 8'h11. Repeat with `BYPASS`=0 → old r4 value / 8'h11.
- Scoreboard: reserve r6, next cycle read r6 → `stall`=1, `rd_valid`=0, data held. Write 8'h77 to r6 in a later cycle while reading r6 → `stall`=0, data 8'h77. The following read of r6 does not stall.
- Zero register (`ZERO_REG`=1): write 8'hFF to r0 and reserve r0, then read r0 → data 0, `stall`=0. Also parametrise `DATA_W`=16, `ADDR_W`=4: write 16'hBEEF to r15 and read it back.
- Async reset mid-read: after writing r1=8'h22 and reading it, assert `rst` between edges → `rd_data1`=0 and `rd_valid`=0 immediately, busy bits cleared.

Source files
------------

// File: rtl/regfile_param.sv
// regfile_param: parametrised register bank with a per-register busy scoreboard.
//   Two registered read ports with one-cycle latency, one write port, and an
//   optional same-cycle write-to-read bypass.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   rd_en               read request for both ports
//   rd_addr1/rd_addr2   read addresses
//   rd_data1/rd_data2   registered read data (held when no read is accepted)
//   rd_valid            one-cycle pulse after an accepted read
//   wr_en/wr_addr/wr_data  write port; a write also clears the busy bit
//   rsv_en/rsv_addr     reserve a destination register (sets busy)
//   stall               combinational: the current read is refused
module regfile_param #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              stall
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;

  logic              wr_ok;
  logic              rsv_ok;
  logic              hit1;
  logic              hit2;
  logic              src_busy1;
  logic              src_busy2;
  logic              accept;
  logic [DATA_W-1:0] src1;
  logic [DATA_W-1:0] src2;

  // Writes and reserves aimed at a hardwired zero register are dropped here,
  // so register 0 is never written and never becomes busy.
  assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // A same-cycle write to a source register resolves its dependency.
  assign hit1 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr1);
  assign hit2 = (BYPASS != 0) && wr_en && (wr_addr == rd_addr2);

  assign src_busy1 = busy[rd_addr1] && !hit1;
  assign src_busy2 = busy[rd_addr2] && !hit2;

  assign stall  = rd_en && (src_busy1 || src_busy2);
  assign accept = rd_en && !stall;

  always_comb begin
    src1 = regs[rd_addr1];
    if ((ZERO_REG != 0) && (rd_addr1 == '0)) src1 = '0;
    else if (hit1)                           src1 = wr_data;
  end

  always_comb begin
    src2 = regs[rd_addr2];
    if ((ZERO_REG != 0) && (rd_addr2 == '0)) src2 = '0;
    else if (hit2)                           src2 = wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else if (wr_ok) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Reserve is applied after the write clear so it wins on the same address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      if (wr_ok)  busy[wr_addr]  <= 1'b0;
      if (rsv_ok) busy[rsv_addr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data1 <= '0;
      rd_data2 <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= accept;
      if (accept) begin
        rd_data1 <= src1;
        rd_data2 <= src2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
module tb_regfile_param;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        re = 1'b0, we = 1'b0, rsv = 1'b0;
  logic [3:0]  ra1 = '0, ra2 = '0, wa = '0, rsa = '0;
  logic [15:0] wd = '0;

  // instance 0: defaults (8-bit, 8 regs, no zero reg, bypass)
  logic [7:0]  d1a, d2a;
  logic        va, sa;
  // instance 1: 16-bit, 16 regs, zero reg, no bypass
  logic [15:0] d1b, d2b;
  logic        vb, sb;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_param dut0 (
    .clk(clk), .rst(rst), .rd_en(re),
    .rd_addr1(ra1[2:0]), .rd_addr2(ra2[2:0]),
    .rd_data1(d1a), .rd_data2(d2a), .rd_valid(va),
    .wr_en(we), .wr_addr(wa[2:0]), .wr_data(wd[7:0]),
    .rsv_en(rsv), .rsv_addr(rsa[2:0]), .stall(sa)
  );

  regfile_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(0)) dut1 (
    .clk(clk), .rst(rst), .rd_en(re),
    .rd_addr1(ra1), .rd_addr2(ra2),
    .rd_data1(d1b), .rd_data2(d2b), .rd_valid(vb),
    .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rsv_en(rsv), .rsv_addr(rsa), .stall(sb)
  );

  // reference model: one register file per instance
  logic [15:0] m_reg  [2][16];
  bit          m_busy [2][16];
  logic [15:0] m_d1 [2];
  logic [15:0] m_d2 [2];
  bit          m_v  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int amask(int i);
    return (i == 0) ? 7 : 15;
  endfunction

  function automatic logic [15:0] dmask(int i);
    return (i == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic bit has_zero(int i);
    return i == 1;
  endfunction

  function automatic bit has_byp(int i);
    return i == 0;
  endfunction

  function automatic bit fwd(int i, int a);
    return has_byp(i) && we && ((int'(wa) & amask(i)) == a);
  endfunction

  function automatic bit exp_stall(int i);
    int a1 = int'(ra1) & amask(i);
    int a2 = int'(ra2) & amask(i);
    return re && ((m_busy[i][a1] && !fwd(i, a1)) || (m_busy[i][a2] && !fwd(i, a2)));
  endfunction

  function automatic logic [15:0] exp_src(int i, int a);
    if (has_zero(i) && a == 0) return 16'h0;
    if (fwd(i, a)) return wd & dmask(i);
    return m_reg[i][a];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int r = 0; r < 16; r++) begin
        m_reg[i][r]  = '0;
        m_busy[i][r] = 1'b0;
      end
      m_d1[i] = '0;
      m_d2[i] = '0;
      m_v[i]  = 1'b0;
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, "_d1_0"}, 32'(d1a), 32'(m_d1[0]));
    chk({where, "_d2_0"}, 32'(d2a), 32'(m_d2[0]));
    chk({where, "_v_0"},  32'(va),  32'(m_v[0]));
    chk({where, "_d1_1"}, 32'(d1b), 32'(m_d1[1]));
    chk({where, "_d2_1"}, 32'(d2b), 32'(m_d2[1]));
    chk({where, "_v_1"},  32'(vb),  32'(m_v[1]));
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle();
    bit          acc  [2];
    logic [15:0] n1   [2];
    logic [15:0] n2   [2];
    #1;
    chk("stall_0", 32'(sa), 32'(exp_stall(0)));
    chk("stall_1", 32'(sb), 32'(exp_stall(1)));
    for (int i = 0; i < 2; i++) begin
      acc[i] = re && !exp_stall(i);
      n1[i]  = exp_src(i, int'(ra1) & amask(i));
      n2[i]  = exp_src(i, int'(ra2) & amask(i));
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      int w = int'(wa) & amask(i);
      int r = int'(rsa) & amask(i);
      m_v[i] = acc[i];
      if (acc[i]) begin
        m_d1[i] = n1[i];
        m_d2[i] = n2[i];
      end
      if (we && !(has_zero(i) && w == 0)) begin
        m_reg[i][w]  = wd & dmask(i);
        m_busy[i][w] = 1'b0;
      end
      if (rsv && !(has_zero(i) && r == 0)) m_busy[i][r] = 1'b1;
    end
    #1;
    check_outputs("post");
    @(negedge clk);
  endtask

  task automatic idle();
    re = 0; we = 0; rsv = 0;
    ra1 = '0; ra2 = '0; wa = '0; rsa = '0; wd = '0;
  endtask

  task automatic op_read(input logic [3:0] a1, input logic [3:0] a2);
    idle(); re = 1; ra1 = a1; ra2 = a2;
  endtask

  task automatic op_write(input logic [3:0] a, input logic [15:0] d);
    idle(); we = 1; wa = a; wd = d;
  endtask

  // Reset pulse strictly between edges; outputs must clear without a clock.
  task automatic mid_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("rst");
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    idle();
    repeat (2) @(negedge clk);
    check_outputs("por");
    rst = 1'b0;

    // reset then read r3/r5
    op_read(4'd3, 4'd5); cycle();
    chk("rst_read_d1", 32'(d1a), 32'h0);
    chk("rst_read_v",  32'(va),  32'h1);

    // write then read
    op_write(4'd2, 16'h00A5); cycle();
    op_read(4'd2, 4'd2); cycle();
    chk("wr_rd_d1", 32'(d1a), 32'hA5);
    chk("wr_rd_d2", 32'(d2a), 32'hA5);

    // bypass vs no bypass
    op_write(4'd1, 16'h0011); cycle();
    op_write(4'd4, 16'h0055); cycle();
    op_read(4'd4, 4'd1); we = 1; wa = 4'd4; wd = 16'h003C; cycle();
    chk("byp_d1", 32'(d1a), 32'h3C);
    chk("byp_d2", 32'(d2a), 32'h11);
    chk("nobyp_d1", 32'(d1b), 32'h55);
    chk("nobyp_d2", 32'(d2b), 32'h11);

    // scoreboard
    idle(); rsv = 1; rsa = 4'd6; cycle();
    op_read(4'd6, 4'd6);
    #1 chk("sb_stall", 32'(sa), 32'h1);
    cycle();
    chk("sb_valid", 32'(va), 32'h0);
    chk("sb_hold",  32'(d1a), 32'h3C);
    op_read(4'd6, 4'd6); we = 1; wa = 4'd6; wd = 16'h0077;
    #1 chk("sb_wr_stall", 32'(sa), 32'h0);
    cycle();
    chk("sb_wr_d1", 32'(d1a), 32'h77);
    op_read(4'd6, 4'd6); cycle();
    chk("sb_after_v", 32'(vb), 32'h1);
    chk("sb_after_d", 32'(d1b), 32'h77);

    // zero register on instance 1
    op_write(4'd0, 16'hFFFF); rsv = 1; rsa = 4'd0; cycle();
    op_read(4'd0, 4'd0);
    #1 chk("zr_stall", 32'(sb), 32'h0);
    cycle();
    chk("zr_data", 32'(d1b), 32'h0);

    // wide instance, top register
    op_write(4'd15, 16'hBEEF); cycle();
    op_read(4'd15, 4'd15); cycle();
    chk("wide_d1", 32'(d1b), 32'hBEEF);
    chk("wide_d2", 32'(d2b), 32'hBEEF);

    // async reset mid-read
    idle(); rsv = 1; rsa = 4'd3; cycle();
    op_write(4'd1, 16'h0022); cycle();
    op_read(4'd1, 4'd1); cycle();
    chk("pre_rst_d1", 32'(d1a), 32'h22);
    mid_reset();
    chk("mid_rst_d1", 32'(d1a), 32'h0);
    chk("mid_rst_v",  32'(va),  32'h0);
    op_read(4'd3, 4'd1);
    #1 chk("rst_busy_clr", 32'(sa), 32'h0);
    cycle();
    chk("rst_reg_clr", 32'(d2a), 32'h0);

    // randomized traffic, addresses biased low to provoke hazards
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 149) == 0) mid_reset();
      re  = 1'($urandom_range(0, 1));
      we  = 1'($urandom_range(0, 1));
      rsv = ($urandom_range(0, 2) == 0);
      ra1 = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 3));
      ra2 = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 3));
      wa  = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 3));
      rsa = 4'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 15 : 3));
      wd  = 16'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
